// File: rtl/mem_arbiter_pkg.sv
// Shared types for the cache<->memory arbiter: grant-state encoding and RAM handshake state.
// Purely declarative; no timing or flow-control behaviour lives here.
package mem_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE   = 2'd0;
    localparam arb_state_t IGRANT = 2'd1;
    localparam arb_state_t DGRANT = 2'd2;
    localparam arb_state_t DONE   = 2'd3;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam int WAIT_CNT_W = 8;

    // ERROR ends a transfer just like ACCESS; the caller decides what data to return.
    function automatic logic ram_finished(input logic [1:0] rs);
        return (rs == ACCESS) || (rs == ERROR);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache onto one RAM port; strobes one cycle after a request, wait pulses low
// in the ACCESS cycle, then a one-cycle DONE bubble. Requesters are held off by wait until served.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 255,
    parameter bit IFAIR   = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              err_timeout
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_C = WAIT_CNT_W'(TIMEOUT);
    localparam logic [WAIT_CNT_W-1:0] CNT_MAX   = '1;

    arb_state_t              state, state_d;
    logic [WORD_W-1:0]       iload_q, dload_q;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    fair_q, fair_d;
    logic                    err_q, err_d;
    logic                    fin;
    logic                    ram_err;
    logic                    d_req;

    assign fin         = ram_finished(ramstate);
    assign ram_err     = (ramstate == ERROR);
    assign d_req       = dREN | dWEN;
    assign err_timeout = err_q;

    always_comb begin
        state_d  = state;
        iwait    = 1'b1;
        dwait    = 1'b1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = iload_q;
        dload    = dload_q;
        cnt_d    = cnt_q;
        fair_d   = fair_q;
        err_d    = err_q;

        case (state)
            IDLE: begin
                // dcache wins ties unless the icache was passed over by the previous dcache grant
                if (d_req && !(fair_q && iREN)) begin
                    state_d = DGRANT;
                    cnt_d   = '0;
                end else if (iREN) begin
                    state_d = IGRANT;
                    cnt_d   = '0;
                    fair_d  = 1'b0;
                end
            end
            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = IDLE;
                end else if (fin) begin
                    iwait   = 1'b0;
                    iload   = ram_err ? '0 : ramload;
                    err_d   = err_q | ram_err;
                    state_d = DONE;
                end
            end
            DGRANT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!d_req) begin
                    state_d = IDLE;
                end else if (fin) begin
                    dwait = 1'b0;
                    if (!dWEN) begin
                        dload = ram_err ? '0 : ramload;
                    end
                    fair_d  = IFAIR & iREN;
                    err_d   = err_q | ram_err;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Timeout only flags the stall; the grant keeps waiting for the RAM.
        if ((state == IGRANT || state == DGRANT) && !fin) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            if (cnt_d >= TIMEOUT_C) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            iload_q <= '0;
            dload_q <= '0;
            cnt_q   <= '0;
            fair_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            iload_q <= iload;
            dload_q <= dload;
            cnt_q   <= cnt_d;
            fair_q  <= fair_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int TMO = 255;

    logic        CLK, RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, err_timeout;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.WORD_W(32), .TIMEOUT(TMO), .IFAIR(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err_timeout(err_timeout)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Transaction-level model: who owns the RAM, whether we are in the post-transfer bubble,
    // how long the current owner has been stalled, and the sticky/held outputs.
    int          owner = 0;   // 0 nobody, 1 icache, 2 dcache
    bit          bubble = 0;
    int          stall = 0;
    bit          m_err = 0, m_fair = 0;
    logic [31:0] m_iload = 0, m_dload = 0;

    always @(negedge CLK) begin
        logic        e_iw, e_dw, e_rr, e_rw;
        logic [31:0] e_addr, e_store, e_il, e_dl;
        bit          finished, bad, wants_d;
        e_iw = 1; e_dw = 1; e_rr = 0; e_rw = 0; e_addr = 0; e_store = 0;
        finished = (ramstate == 2'd2) || (ramstate == 2'd3);
        bad      = (ramstate == 2'd3);
        wants_d  = dREN || dWEN;
        if (RST) begin
            owner = 0; bubble = 0; stall = 0; m_err = 0; m_fair = 0; m_iload = 0; m_dload = 0;
        end
        e_il = m_iload;
        e_dl = m_dload;
        if (!RST && owner == 1) begin
            e_rr = 1; e_addr = iaddr;
            if (iREN && finished) begin
                e_iw = 0; e_il = bad ? 32'h0 : ramload;
            end
        end
        if (!RST && owner == 2) begin
            e_rw = dWEN; e_rr = dREN && !dWEN; e_addr = daddr; e_store = dstore;
            if (wants_d && finished) begin
                e_dw = 0;
                if (!dWEN) e_dl = bad ? 32'h0 : ramload;
            end
        end
        check("iwait", iwait, e_iw);
        check("dwait", dwait, e_dw);
        check("ramREN", ramREN, e_rr);
        check("ramWEN", ramWEN, e_rw);
        check("ramaddr", ramaddr, e_addr);
        check("ramstore", ramstore, e_store);
        check("iload", iload, e_il);
        check("dload", dload, e_dl);
        check("err_timeout", err_timeout, m_err);

        if (!RST) begin
            if (bubble) begin
                bubble = 0;
            end else if (owner == 0) begin
                if (wants_d && !(m_fair && iREN)) begin
                    owner = 2; stall = 0;
                end else if (iREN) begin
                    owner = 1; stall = 0; m_fair = 0;
                end
            end else begin
                if (!finished) begin
                    if (stall < 255) stall++;
                    if (stall >= TMO) m_err = 1;
                end
                if ((owner == 1 && !iREN) || (owner == 2 && !wants_d)) begin
                    owner = 0;
                end else if (finished) begin
                    if (owner == 2) m_fair = iREN;
                    if (bad) m_err = 1;
                    m_iload = e_il; m_dload = e_dl;
                    owner = 0; bubble = 1;
                end
            end
        end
    end

    initial begin
        RST = 1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
        tick(); tick();
        @(negedge CLK);
        check("rst_iwait", iwait, 1);
        check("rst_dwait", dwait, 1);
        check("rst_err", err_timeout, 0);
        tick();
        RST = 0;

        // 1: icache fetch completing after three stalled cycles
        iREN = 1; iaddr = 32'h40; ramstate = 2'd1;
        @(negedge CLK); check("t1_idle_rren", ramREN, 0);
        tick();
        @(negedge CLK); check("t1_rren", ramREN, 1); check("t1_addr", ramaddr, 32'h40);
        tick(); tick();
        ramstate = 2'd2; ramload = 32'hDEADBEEF;
        @(negedge CLK); check("t1_iwait", iwait, 0); check("t1_iload", iload, 32'hDEADBEEF);
        tick();
        iREN = 0; ramstate = 2'd0; ramload = 32'h0;
        @(negedge CLK); check("t1_bubble_iwait", iwait, 1); check("t1_iload_hold", iload, 32'hDEADBEEF);
        tick();

        // 2: simultaneous write and fetch; write first, then fairness hands the tie to icache
        dWEN = 1; daddr = 32'h80; dstore = 32'h1234; iREN = 1; iaddr = 32'h44; ramstate = 2'd1;
        tick();
        ramstate = 2'd2;
        @(negedge CLK);
        check("t2_rwen", ramWEN, 1); check("t2_store", ramstore, 32'h1234);
        check("t2_addr", ramaddr, 32'h80); check("t2_dwait", dwait, 0); check("t2_iwait", iwait, 1);
        tick();
        dWEN = 0; ramstate = 2'd1;
        tick();
        dWEN = 1;
        tick();
        ramstate = 2'd2; ramload = 32'h1111;
        @(negedge CLK);
        check("t2_fair_rren", ramREN, 1); check("t2_fair_rwen", ramWEN, 0);
        check("t2_fair_addr", ramaddr, 32'h44); check("t2_fair_iwait", iwait, 0);
        tick();
        iREN = 0; dWEN = 0; ramstate = 2'd0;
        tick(); tick();

        // 3: read and write together -> write wins, dload untouched
        dREN = 1; dWEN = 1; daddr = 32'h88; dstore = 32'h55; ramstate = 2'd1;
        tick();
        ramstate = 2'd2; ramload = 32'hAAAA;
        @(negedge CLK);
        check("t3_rwen", ramWEN, 1); check("t3_rren", ramREN, 0);
        check("t3_dwait", dwait, 0); check("t3_dload", dload, 32'h0);
        tick();
        dREN = 0; dWEN = 0; ramstate = 2'd0;
        tick();

        // 5: fetch withdrawn two cycles into its grant
        iREN = 1; iaddr = 32'h50; ramstate = 2'd1;
        tick();
        @(negedge CLK); check("t5_rren", ramREN, 1);
        tick();
        iREN = 0;
        @(negedge CLK); check("t5_drop_iwait", iwait, 1);
        tick();
        @(negedge CLK); check("t5_after_rren", ramREN, 0); check("t5_after_iwait", iwait, 1);
        tick();

        // 4: RAM stuck busy past the timeout; grant holds, then completes
        iREN = 1; iaddr = 32'h60; ramstate = 2'd1;
        tick();
        for (int k = 1; k <= 300; k++) begin
            @(negedge CLK);
            if (k == TMO) check("t4_err_before", err_timeout, 0);
            if (k == TMO + 1) begin
                check("t4_err_set", err_timeout, 1);
                check("t4_still_granted", ramREN, 1);
            end
            tick();
        end
        ramstate = 2'd2; ramload = 32'h77;
        @(negedge CLK); check("t4_iwait", iwait, 0); check("t4_iload", iload, 32'h77);
        tick();
        iREN = 0; ramstate = 2'd0;
        tick();

        // 6: asynchronous reset in the middle of a dcache write grant
        dWEN = 1; daddr = 32'h90; dstore = 32'h99; ramstate = 2'd1;
        tick();
        @(negedge CLK); check("t6_rwen", ramWEN, 1); check("t6_err_sticky", err_timeout, 1);
        #2 RST = 1;
        #1;
        check("t6_rwen_rst", ramWEN, 0); check("t6_dwait_rst", dwait, 1); check("t6_err_rst", err_timeout, 0);
        tick();
        @(negedge CLK);
        tick();
        RST = 0; dWEN = 0; ramstate = 2'd0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            tick();
            if (RST) RST = 0;
            else if ($urandom_range(0, 499) == 0) RST = 1;
            if ($urandom_range(0, 5) == 0) iREN = ~iREN;
            if ($urandom_range(0, 7) == 0) dREN = ~dREN;
            if ($urandom_range(0, 9) == 0) dWEN = ~dWEN;
            if ($urandom_range(0, 3) == 0) iaddr = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 3) == 0) daddr = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 2) == 0) dstore = $urandom;
            r = $urandom_range(0, 99);
            ramstate = (r < 30) ? 2'd2 : (r < 31) ? 2'd3 : (r < 90) ? 2'd1 : 2'd0;
            ramload = $urandom;
        end
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
